// File: rtl/dmem_pkg.sv
// dmem_pkg: state/width types and lane helpers for the MEM-stage load/store unit
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} dmem_state_t;
  typedef enum logic [1:0] {W_BYTE, W_HALF, W_WORD} mem_width_t;
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  function automatic mem_width_t load_width(regfilemux::regfilemux_sel_t sel);
    return (sel == regfilemux::lb || sel == regfilemux::lbu) ? W_BYTE :
           (sel == regfilemux::lh || sel == regfilemux::lhu) ? W_HALF : W_WORD;
  endfunction
  function automatic mem_width_t store_width(logic [2:0] f3);
    return f3 == F3_SB ? W_BYTE : f3 == F3_SH ? W_HALF : W_WORD;
  endfunction
  function automatic logic is_misaligned(mem_width_t w, logic [1:0] off);
    return (w == W_HALF && off[0]) || (w == W_WORD && off != 2'b00);
  endfunction
  function automatic logic [3:0] byte_en(mem_width_t w, logic [1:0] off);
    return w == W_BYTE ? 4'b0001 << off : w == W_HALF ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
  endfunction
  function automatic logic [31:0] replicate(mem_width_t w, logic [31:0] d);
    return w == W_BYTE ? {4{d[7:0]}} : w == W_HALF ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/regfilemux.sv
// regfilemux: writeback mux select encodings shared by the MEM stage
package regfilemux;
  typedef enum logic [3:0] {
    alu_out, br_en, u_imm, lw, pc_plus4, lb, lbu, lh, lhu
  } regfilemux_sel_t;
endpackage

// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: EX/MEM request, data-cache bus and pipeline response signals
interface dmem_access_unit_if;
  logic                        req_valid, req_load, req_store;
  logic [2:0]                  funct3;
  regfilemux::regfilemux_sel_t load_sel;
  logic [31:0]                 addr, store_data;
  logic                        dmem_read, dmem_write;
  logic [31:0]                 dmem_address, dmem_wdata;
  logic [3:0]                  dmem_byte_enable;
  logic                        dmem_resp;
  logic [31:0]                 dmem_rdata;
  logic                        stall, load_valid, misaligned, timeout_err;
  logic [31:0]                 load_data;
  modport slave (
    input  req_valid, req_load, req_store, funct3, load_sel, addr, store_data, dmem_resp, dmem_rdata,
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
           stall, load_data, load_valid, misaligned, timeout_err
  );
  modport master (
    output req_valid, req_load, req_store, funct3, load_sel, addr, store_data, dmem_resp, dmem_rdata,
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
           stall, load_data, load_valid, misaligned, timeout_err
  );
endinterface

// File: rtl/dmem_load_aligner.sv
// dmem_load_aligner: selects and extends the loaded byte/half/word from a cache word
module dmem_load_aligner (
  input  logic [31:0]                 i_rdata,
  input  logic [1:0]                  i_off,
  input  regfilemux::regfilemux_sel_t i_sel,
  output logic [31:0]                 o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  always_comb begin
    w_byte = i_rdata[{i_off, 3'b000} +: 8];
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_data = (i_sel == regfilemux::lb)  ? {{24{w_byte[7]}}, w_byte} :
             (i_sel == regfilemux::lbu) ? {24'b0, w_byte} :
             (i_sel == regfilemux::lh)  ? {{16{w_half[15]}}, w_half} :
             (i_sel == regfilemux::lhu) ? {16'b0, w_half} : i_rdata;
  end
endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage load/store FSM driving one data-cache transaction per request
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TO_CNT_W       = 16
) (
  input logic               clk,
  input logic               rst,
  dmem_access_unit_if.slave bus
);
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);
  dmem_state_t                 r_state;
  logic                        r_read, r_write, r_is_load, r_timeout_err;
  logic [31:0]                 r_address, r_wdata, r_load_data;
  logic [3:0]                  r_be;
  logic [1:0]                  r_off;
  regfilemux::regfilemux_sel_t r_sel;
  logic [TO_CNT_W-1:0]         r_cnt;
  mem_width_t                  w_width;
  logic                        w_req, w_mis, w_go;
  logic [31:0]                 w_aligned;
  // a request with both load and store set is handled as a load
  assign w_width = bus.req_load ? load_width(bus.load_sel) : store_width(bus.funct3);
  assign w_req   = !rst && r_state == IDLE && bus.req_valid && (bus.req_load || bus.req_store);
  assign w_mis   = w_req && is_misaligned(w_width, bus.addr[1:0]);
  assign w_go    = w_req && !w_mis;
  dmem_load_aligner u_align (
    .i_rdata (bus.dmem_rdata),
    .i_off   (r_off),
    .i_sel   (r_sel),
    .o_data  (w_aligned)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_read        <= 1'b0;
      r_write       <= 1'b0;
      r_is_load     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_address     <= '0;
      r_wdata       <= '0;
      r_load_data   <= '0;
      r_be          <= '0;
      r_off         <= '0;
      r_sel         <= regfilemux::alu_out;
      r_cnt         <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_go) begin
          r_state   <= ACCESS;
          r_read    <= bus.req_load;
          r_write   <= !bus.req_load;
          r_is_load <= bus.req_load;
          r_address <= {bus.addr[31:2], 2'b00};
          r_be      <= byte_en(w_width, bus.addr[1:0]);
          r_wdata   <= bus.req_load ? 32'b0 : replicate(w_width, bus.store_data);
          r_off     <= bus.addr[1:0];
          r_sel     <= bus.load_sel;
          r_cnt     <= '0;
        end
        ACCESS: begin
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          // the flag marks the cycle the count reaches the limit without a response
          if (TIMEOUT_CYCLES != 0 && !bus.dmem_resp && r_cnt >= TO_LAST) r_timeout_err <= 1'b1;
          if (bus.dmem_resp) begin
            r_state <= DONE;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            if (r_is_load) r_load_data <= w_aligned;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.dmem_read        = r_read;
  assign bus.dmem_write       = r_write;
  assign bus.dmem_address     = r_address;
  assign bus.dmem_wdata       = r_wdata;
  assign bus.dmem_byte_enable = r_be;
  assign bus.stall            = w_go || r_state == ACCESS;
  assign bus.misaligned       = w_mis;
  assign bus.load_valid       = r_state == DONE && r_is_load;
  assign bus.load_data        = r_load_data;
  assign bus.timeout_err      = r_timeout_err;
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed stimulus with a queue-based scoreboard monitor
module tb_dmem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_access_unit_if bus ();
  dmem_access_unit #(.TIMEOUT_CYCLES(4), .TO_CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        rd, wr;
    logic [31:0] a, wd;
    logic [3:0]  be;
  } txn_t;
  txn_t        exp_txn[$];
  logic [31:0] exp_load[$];
  int          exp_stall[$], exp_req[$], exp_mis[$];
  int          checks = 0, failures = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // monitor: compares DUT outputs against the expectation queues
  logic prev_req = 1'b0;
  int   stall_run = 0, req_run = 0;
  txn_t t;
  initial forever begin
    @(negedge clk);
    if ((bus.dmem_read || bus.dmem_write) && !prev_req) begin
      if (exp_txn.size() == 0) chk("txn_unexpected", 1, 0);
      else begin
        t = exp_txn.pop_front();
        chk("txn_rw", {30'b0, bus.dmem_read, bus.dmem_write}, {30'b0, t.rd, t.wr});
        chk("txn_addr", bus.dmem_address, t.a);
        chk("txn_be", {28'b0, bus.dmem_byte_enable}, {28'b0, t.be});
        chk("txn_wdata", bus.dmem_wdata, t.wd);
      end
    end
    prev_req = bus.dmem_read || bus.dmem_write;
    if (prev_req) req_run++;
    else if (req_run > 0) begin
      if (exp_req.size() == 0) chk("req_len_unexpected", 1, 0);
      else chk("req_len", req_run, exp_req.pop_front());
      req_run = 0;
    end
    if (bus.stall) stall_run++;
    else if (stall_run > 0) begin
      if (exp_stall.size() == 0) chk("stall_len_unexpected", 1, 0);
      else chk("stall_len", stall_run, exp_stall.pop_front());
      stall_run = 0;
    end
    if (bus.load_valid) begin
      if (exp_load.size() == 0) chk("load_unexpected", 1, 0);
      else chk("load_data", bus.load_data, exp_load.pop_front());
    end
    if (bus.misaligned) begin
      if (exp_mis.size() == 0) chk("mis_unexpected", 1, 0);
      else begin
        void'(exp_mis.pop_front());
        chk("mis_stall", bus.stall, 0);
        chk("mis_no_access", bus.dmem_read || bus.dmem_write, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input regfilemux::regfilemux_sel_t sel, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid  = 1'b1;
    bus.req_load   = ld;
    bus.req_store  = st;
    bus.funct3     = f3;
    bus.load_sel   = sel;
    bus.addr       = a;
    bus.store_data = d;
  endtask

  task automatic expect_txn(input logic rd, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] wd, input int k);
    exp_txn.push_back('{rd: rd, wr: !rd, a: a, wd: wd, be: be});
    exp_stall.push_back(k + 1);
    exp_req.push_back(k);
  endtask

  task automatic xact(input logic ld, input logic st, input logic [2:0] f3,
                      input regfilemux::regfilemux_sel_t sel, input logic [31:0] a,
                      input logic [31:0] d, input int k, input logic [31:0] rd);
    issue(ld, st, f3, sel, a, d);
    repeat (k) step();
    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = rd;
    step();
    bus.dmem_resp  = 1'b0;
    bus.dmem_rdata = '0;
    step();
    bus.req_valid  = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bus.req_valid = 0; bus.req_load = 0; bus.req_store = 0; bus.funct3 = 0;
    bus.load_sel = regfilemux::alu_out; bus.addr = 0; bus.store_data = 0;
    bus.dmem_resp = 0; bus.dmem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_stall", bus.stall, 0);
    chk("rst_rw", bus.dmem_read || bus.dmem_write, 0);
    chk("rst_addr", bus.dmem_address, 0);
    chk("rst_load_valid", bus.load_valid, 0);
    chk("rst_load_data", bus.load_data, 0);
    chk("rst_timeout", bus.timeout_err, 0);
    step();
    rst = 1'b0;
    step();

    expect_txn(1, 32'h100, 4'b1000, 0, 1); exp_load.push_back(32'hFFFF_FF80);
    xact(1, 0, 3'b000, regfilemux::lb, 32'h103, 0, 1, 32'h80FF_1234);
    expect_txn(1, 32'h200, 4'b1100, 0, 1); exp_load.push_back(32'h0000_BEEF);
    xact(1, 0, 3'b000, regfilemux::lhu, 32'h202, 0, 1, 32'hBEEF_0000);
    expect_txn(1, 32'h200, 4'b1100, 0, 1); exp_load.push_back(32'hFFFF_BEEF);
    xact(1, 0, 3'b000, regfilemux::lh, 32'h202, 0, 1, 32'hBEEF_0000);
    expect_txn(1, 32'h100, 4'b0100, 0, 2); exp_load.push_back(32'h0000_00FF);
    xact(1, 0, 3'b000, regfilemux::lbu, 32'h102, 0, 2, 32'h80FF_1234);
    expect_txn(0, 32'h300, 4'b0010, 32'hA5A5_A5A5, 4);
    xact(0, 1, 3'b000, regfilemux::alu_out, 32'h301, 32'h0000_00A5, 4, 32'h0);
    expect_txn(0, 32'h700, 4'b1100, 32'hBEEF_BEEF, 1);
    xact(0, 1, 3'b001, regfilemux::alu_out, 32'h702, 32'h1234_BEEF, 1, 32'h0);
    expect_txn(0, 32'h40C, 4'b1111, 32'h1234_5678, 2);
    xact(0, 1, 3'b010, regfilemux::alu_out, 32'h40C, 32'h1234_5678, 2, 32'h0);

    exp_mis.push_back(1);
    issue(1, 0, 3'b000, regfilemux::lw, 32'h402, 0);
    step(); bus.req_valid = 1'b0; step();
    exp_mis.push_back(1);
    issue(0, 1, 3'b001, regfilemux::alu_out, 32'h405, 32'h1111);
    step(); bus.req_valid = 1'b0; step();

    chk("timeout_clear_before", bus.timeout_err, 0);
    expect_txn(1, 32'h500, 4'b1111, 0, 8); exp_load.push_back(32'hCAFE_F00D);
    issue(1, 0, 3'b000, regfilemux::lw, 32'h500, 0);
    repeat (4) step();
    @(negedge clk); chk("timeout_not_yet", bus.timeout_err, 0);
    step();
    @(negedge clk); chk("timeout_set", bus.timeout_err, 1);
    repeat (3) step();
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'hCAFE_F00D;
    step();
    bus.dmem_resp = 1'b0; bus.dmem_rdata = '0;
    @(negedge clk); chk("timeout_sticky", bus.timeout_err, 1);
    step(); bus.req_valid = 1'b0; step();

    exp_txn.push_back('{rd: 1, wr: 0, a: 32'h600, wd: 0, be: 4'b1111});
    exp_stall.push_back(3);
    exp_req.push_back(2);
    issue(1, 0, 3'b000, regfilemux::lw, 32'h600, 0);
    repeat (3) step();
    #2; rst = 1'b1; bus.req_valid = 1'b0;
    #1;
    chk("rst_mid_read", bus.dmem_read, 0);
    chk("rst_mid_stall", bus.stall, 0);
    chk("rst_mid_timeout", bus.timeout_err, 0);
    rst = 1'b0;
    step();
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'hDEAD_BEEF;
    step();
    bus.dmem_resp = 1'b0; bus.dmem_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stray_load_valid", bus.load_valid, 0);
      chk("stray_stall", bus.stall, 0);
      chk("stray_read", bus.dmem_read, 0);
      step();
    end

    repeat (2) step();
    chk("left_txn", exp_txn.size(), 0);
    chk("left_load", exp_load.size(), 0);
    chk("left_stall", exp_stall.size(), 0);
    chk("left_req", exp_req.size(), 0);
    chk("left_mis", exp_mis.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
